// File: rtl/parameterized_reload_down_counter_pkg.sv
// parameterized_reload_down_counter_pkg: shared counter state encoding and default width.
package parameterized_reload_down_counter_pkg;

   localparam int PRDC_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/parameterized_reload_down_counter_if.sv
// parameterized_reload_down_counter_if: load handshake, control and status bundle of the reload down-counter.
interface parameterized_reload_down_counter_if
   import parameterized_reload_down_counter_pkg::*;
#(
   parameter int WIDTH = PRDC_WIDTH
);
   logic             load_valid;
   logic [WIDTH-1:0] load_value;
   logic             load_ready;
   logic             start;
   logic             stop;
   logic             enable;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             tc;

   modport master (
      output load_valid, load_value, start, stop, enable, auto_reload,
      input  load_ready, count, busy, done, tc
   );

   modport slave (
      input  load_valid, load_value, start, stop, enable, auto_reload,
      output load_ready, count, busy, done, tc
   );
endinterface

// File: rtl/parameterized_reload_down_counter.sv
// parameterized_reload_down_counter: loadable down-counter/timer with one-shot or auto-reload terminal count.
module parameterized_reload_down_counter
   import parameterized_reload_down_counter_pkg::*;
#(
   parameter int WIDTH = PRDC_WIDTH
) (
   input logic clk,
   input logic rst_n,
   parameterized_reload_down_counter_if.slave bus
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             load_acc, restart, step, term;

   assign load_acc = bus.load_valid && (state_q != RUN);
   assign restart  = (state_q == DONE) && bus.start && (reload_q != '0);
   assign step     = (state_q == RUN) && !bus.stop && bus.enable;
   assign term     = step && (count_q == WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // the unused encoding 2'b11 falls through to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (!load_acc && bus.start && count_q != '0) ? RUN : IDLE;
         RUN:     state_d = bus.stop ? IDLE : (term && !bus.auto_reload) ? DONE : RUN;
         DONE:    state_d = load_acc ? IDLE : restart ? RUN : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load_acc) begin
         count_d  = bus.load_value;
         reload_d = bus.load_value;
      end else if (restart) begin
         count_d = reload_q;
      end else if (term) begin
         count_d = bus.auto_reload ? reload_q : '0;
         tc_d    = 1'b1;
      end else if (step && count_q > WIDTH'(1)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_comb begin
      bus.load_ready = (state_q != RUN);
      bus.busy       = (state_q == RUN);
      bus.done       = (state_q == DONE);
      bus.count      = count_q;
      bus.tc         = tc_q;
   end
endmodule

// File: tb/tb_parameterized_reload_down_counter.sv
// tb_parameterized_reload_down_counter: directed and random stimulus against a behavioural timer model.
module tb_parameterized_reload_down_counter;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // model: remaining ticks, last loaded period, and whether it is counting / has expired
   int   m_count, m_reload;
   bit   m_run, m_done, m_tc;

   parameterized_reload_down_counter_if #(.WIDTH(W)) bus ();

   parameterized_reload_down_counter #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_reload = 0; m_run = 0; m_done = 0; m_tc = 0;
   endtask

   task automatic model_step();
      m_tc = 0;
      if (!m_run) begin
         if (bus.load_valid) begin
            m_count = int'(bus.load_value); m_reload = m_count; m_done = 0;
         end else if (bus.start) begin
            if (m_done) begin
               if (m_reload != 0) begin m_count = m_reload; m_run = 1; m_done = 0; end
            end else if (m_count != 0) m_run = 1;
         end
      end else if (bus.stop) begin
         m_run = 0;
      end else if (bus.enable) begin
         if (m_count > 1) m_count--;
         else begin
            m_tc = 1;
            if (bus.auto_reload) m_count = m_reload;
            else begin m_count = 0; m_run = 0; m_done = 1; end
         end
      end
   endtask

   task automatic check_model();
      chk("count", 32'(bus.count), 32'(m_count));
      chk("busy", 32'(bus.busy), 32'(m_run));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("tc", 32'(bus.tc), 32'(m_tc));
      chk("load_ready", 32'(bus.load_ready), 32'(!m_run));
   endtask

   task automatic drive(input bit lv, input int lval, input bit st, input bit sp, input bit en, input bit ar);
      bus.load_valid = lv; bus.load_value = W'(lval); bus.start = st;
      bus.stop = sp; bus.enable = en; bus.auto_reload = ar;
   endtask

   task automatic cyc();
      if (rst_n) model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #3;
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      // one-shot load 5
      drive(1, 5, 0, 0, 1, 0); cyc();
      drive(0, 0, 1, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 1, 0);
      repeat (5) cyc();
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_tc", 32'(bus.tc), 1);
      chk("t1_count", 32'(bus.count), 0);
      cyc();
      chk("t1_tc_drop", 32'(bus.tc), 0);
      // auto-reload 3
      drive(1, 3, 0, 0, 1, 1); cyc();
      drive(0, 0, 1, 0, 1, 1); cyc();
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 1; i <= 9; i++) begin
         cyc();
         chk("t2_tc", 32'(bus.tc), 32'(i % 3 == 0));
      end
      chk("t2_done", 32'(bus.done), 0);
      drive(0, 0, 0, 1, 1, 0); cyc();
      // enable gap then stop at count 1
      drive(1, 4, 0, 0, 1, 0); cyc();
      drive(0, 0, 1, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
      chk("t3_hold", 32'(bus.count), 3);
      drive(0, 0, 0, 0, 1, 0); cyc(); cyc();
      chk("t3_one", 32'(bus.count), 1);
      drive(0, 0, 0, 1, 1, 0); cyc();
      chk("t3_stop_busy", 32'(bus.busy), 0);
      chk("t3_stop_count", 32'(bus.count), 1);
      chk("t3_stop_tc", 32'(bus.tc), 0);
      // restart from DONE, zero load, load+start
      drive(1, 2, 0, 0, 1, 0); cyc();
      drive(0, 0, 1, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 1, 0); cyc(); cyc();
      chk("t4_done", 32'(bus.done), 1);
      drive(0, 0, 1, 0, 1, 0); cyc();
      chk("t4_rerun_busy", 32'(bus.busy), 1);
      chk("t4_rerun_count", 32'(bus.count), 2);
      drive(0, 0, 0, 0, 1, 0); cyc(); cyc();
      drive(1, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 1, 0, 1, 0); cyc();
      chk("t4_zero_busy", 32'(bus.busy), 0);
      drive(1, 6, 1, 0, 1, 0); cyc();
      chk("t4_ls_busy", 32'(bus.busy), 0);
      chk("t4_ls_count", 32'(bus.count), 6);
      // load attempt while running
      drive(0, 0, 1, 0, 1, 0); cyc();
      drive(1, 9, 0, 0, 1, 0); cyc();
      chk("t5_ready", 32'(bus.load_ready), 0);
      chk("t5_count", 32'(bus.count), 5);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom % 8 == 0, ($urandom % 4 == 0) ? 255 : int'($urandom % 8),
               $urandom % 4 == 0, $urandom % 16 == 0, $urandom % 4 != 0, $urandom % 2 == 1);
         cyc();
      end
      // async reset with a terminal event pending
      drive(0, 0, 0, 1, 1, 0); cyc();
      drive(1, 3, 0, 0, 1, 0); cyc();
      drive(0, 0, 1, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 1, 0); cyc(); cyc();
      chk("t6_pre_count", 32'(bus.count), 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_count", 32'(bus.count), 0);
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_tc", 32'(bus.tc), 0);
      @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 1, 0); cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/parameterized_reload_down_counter.md
# parameterized_reload_down_counter

Loadable down-counter/timer that consumes a value through a valid/ready load port, counts it down to zero, and signals terminal count. It complements the library's loadable up-counter. It is used wherever a block needs a programmed delay, timeout or periodic tick, in one-shot or auto-reload mode. A small state machine sequences load, start, run and stop.

## Interface
- WIDTH, 8, counter and load-value width (>= 2)
- clk  input  1  clock, all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load_valid  input  1  load request
- load_value  input  WIDTH  value to load
- load_ready  output  1  load accepted when load_valid && load_ready
- start  input  1  begin counting (sampled, level)
- stop  input  1  abort counting (sampled, level)
- enable  input  1  count qualifier while running
- auto_reload  input  1  1 = periodic, 0 = one-shot (sampled at terminal event)
- count  output  WIDTH  current counter value (registered)
- busy  output  1  state == RUN
- done  output  1  state == DONE
- tc  output  1  one-cycle terminal-count pulse (registered)

## Operation
- State registers: count, reload_reg (last accepted load), 2-bit state, tc.
- FSM states: IDLE, RUN, DONE. Reset: state IDLE, count 0, reload_reg 0, tc 0, so busy 0, done 0, load_ready 1.
- load_ready = (state != RUN), combinational from state.
- IDLE/DONE with an accepted load: count <= load_value, reload_reg <= load_value, state -> IDLE. The load takes priority over a same-cycle start, which is ignored.
- IDLE, start, no load: if count != 0, go to RUN. If count == 0, ignore and stay IDLE.
- DONE, start, no load: if reload_reg != 0, count <= reload_reg and go to RUN. Otherwise stay DONE.
- RUN priority order, highest first: stop, then enable. start is ignored in RUN.
  - stop: go to IDLE, count holds, no decrement, no tc.
  - enable = 0: hold.
  - enable = 1 and count > 1: count <= count - 1.
  - enable = 1 and count == 1: terminal event. tc <= 1. If auto_reload, count <= reload_reg and stay RUN. Otherwise count <= 0 and go to DONE.
- tc is 0 in every cycle not following a terminal event.
- Arithmetic is unsigned, WIDTH bits. count never underflows, because the decrement is only taken when count > 1.
- The maximum load value of 2^WIDTH-1 is legal.

## Timing
- Load accepted at edge E: count and load_ready reflect the new state after E.
- Start accepted at edge S: busy = 1 after S. The first decrement occurs at the first enabled edge after S.
- Load L with enable held high, start at edge S: count reaches 0 after edge S+L. done = 1 and tc = 1 for the cycle after S+L. tc is 0 again after S+L+1.
- Auto-reload with reload_reg R and enable held high: tc pulses every R cycles. count sequence is R, R-1, ..., 1, R, ...
- R = 1 with auto-reload: tc is high on every enabled cycle.
- Deasserting enable stretches the period by the number of disabled cycles.
- Asynchronous reset mid-RUN: all outputs take their reset values immediately. A tc pending for the next cycle is discarded.

## Structure
- Shared counters package holds the state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10. 2'b11 is illegal and recovers to IDLE.
- Single flat module. No sub-module: the datapath is one decrementer and one mux.

## Test plan
- Reset, then load 5, then start with enable high: count goes 5, 4, 3, 2, 1, 0. done = 1 and tc = 1 exactly one cycle, 5 cycles after the start edge. load_ready is 0 throughout RUN.
- Auto-reload, load 3, start: tc pulses on cycles 3, 6, 9 after start. count cycles 3, 2, 1, 3, 2, 1. done stays 0.
- Load 4, start, drop enable for 2 cycles mid-count: count holds and tc is delayed by exactly 2 cycles. Then assert stop in the cycle where count == 1: state goes to IDLE, count = 1, no tc.
- In DONE, start with no new load: reloads reload_reg and runs again. Load 0 then start: stays IDLE, no tc. Load and start in the same cycle: load applied, start ignored.
- Drive load_valid during RUN: load_ready = 0 and count is unaffected. Assert rst_n low mid-count: count = 0, busy = 0, tc = 0 immediately, without waiting for a clock edge.
